// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller and the ALU: opcode encodings,
// controller FSM state encodings and the supported-opcode check.
package alu_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      S_WAIT_A  = 3'd0,
      S_WAIT_B  = 3'd1,
      S_WAIT_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_SHOW    = 3'd4
   } state_t;

   function automatic logic op_supported(input logic [OP_W-1:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer with a
// saturating stability counter, and a rising-edge one-cycle press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_reg;
   logic             level_reg;
   logic             level_next;
   logic             level_d_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             synced;

   assign synced = sync_reg[1];

   // The counter tracks how many consecutive samples disagreed with the
   // accepted level; any agreeing sample restarts the count.
   always_comb begin
      level_next = level_reg;
      cnt_next   = cnt_reg;
      if (synced == level_reg) begin
         cnt_next = '0;
      end else if (cnt_reg >= CNT_LAST) begin
         level_next = synced;
         cnt_next   = '0;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg    <= '0;
         level_reg   <= 1'b0;
         level_d_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         sync_reg    <= {sync_reg[0], btn};
         level_reg   <= level_next;
         level_d_reg <= level_reg;
         cnt_reg     <= cnt_next;
      end
   end

   assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/alu_ctrl.sv
// Operand/opcode loader for an external combinational ALU: three debounced
// buttons step through A, B and opcode entry, then the result is latched.
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int NB_DATA         = 4,
   parameter int NB_OP           = 6,
   parameter int NB_SW           = 8,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic [NB_SW-1:0]   i_sw,
   input  logic               i_btn_a,
   input  logic               i_btn_b,
   input  logic               i_btn_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_datoA,
   output logic [NB_DATA-1:0] o_datoB,
   output logic [NB_OP-1:0]   o_operation,
   output logic [NB_DATA-1:0] o_leds,
   output logic               o_valid,
   output logic               o_error,
   output logic [2:0]         o_state
);

   localparam int N_BTN = 3;

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_press;
   logic             press_a;
   logic             press_b;
   logic             press_op;

   assign btn_raw  = {i_btn_op, i_btn_b, i_btn_a};
   assign press_a  = btn_press[0];
   assign press_b  = btn_press[1];
   assign press_op = btn_press[2];

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_btn (
            .clk  (clk),
            .reset(i_reset),
            .btn  (btn_raw[gi]),
            .press(btn_press[gi])
         );
      end
   endgenerate

   logic [NB_DATA-1:0] sw_data;
   logic [NB_OP-1:0]   sw_op;
   logic               op_ok;
   logic               sw_unused;

   assign sw_data   = i_sw[NB_DATA-1:0];
   assign sw_op     = i_sw[NB_OP-1:0];
   assign sw_unused = ^i_sw;

   // A wider opcode bus must carry zeros above the encoded field to match.
   assign op_ok = op_supported(OP_W'(sw_op)) && (NB_OP'(OP_W'(sw_op)) == sw_op);

   state_t             state_reg, state_next;
   logic [NB_DATA-1:0] data_a_reg, data_a_next;
   logic [NB_DATA-1:0] data_b_reg, data_b_next;
   logic [NB_OP-1:0]   op_reg, op_next;
   logic [NB_DATA-1:0] leds_reg, leds_next;
   logic               valid_reg, valid_next;
   logic               error_reg, error_next;

   always_comb begin
      state_next  = state_reg;
      data_a_next = data_a_reg;
      data_b_next = data_b_reg;
      op_next     = op_reg;
      leds_next   = leds_reg;
      valid_next  = valid_reg;
      error_next  = error_reg;
      case (state_reg)
         S_WAIT_A, S_SHOW: begin
            if (press_a) begin
               data_a_next = sw_data;
               valid_next  = 1'b0;
               error_next  = 1'b0;
               state_next  = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (press_b) begin
               data_b_next = sw_data;
               state_next  = S_WAIT_OP;
            end
         end
         S_WAIT_OP: begin
            if (press_op) begin
               if (op_ok) begin
                  op_next    = sw_op;
                  error_next = 1'b0;
                  state_next = S_EXEC;
               end else begin
                  error_next = 1'b1;
               end
            end
         end
         S_EXEC: begin
            // The ALU has had a full cycle to settle on the new opcode.
            leds_next  = i_alu_result;
            valid_next = 1'b1;
            state_next = S_SHOW;
         end
         default: begin
            state_next = S_WAIT_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_reg  <= S_WAIT_A;
         data_a_reg <= '0;
         data_b_reg <= '0;
         op_reg     <= '0;
         leds_reg   <= '0;
         valid_reg  <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         data_a_reg <= data_a_next;
         data_b_reg <= data_b_next;
         op_reg     <= op_next;
         leds_reg   <= leds_next;
         valid_reg  <= valid_next;
         error_reg  <= error_next;
      end
   end

   assign o_datoA     = data_a_reg;
   assign o_datoB     = data_b_reg;
   assign o_operation = op_reg;
   assign o_leds      = leds_reg;
   assign o_valid     = valid_reg;
   assign o_error     = error_reg;
   assign o_state     = state_reg;

endmodule
